dcache_wb_dm: RTL

Direct-mapped, write-back, write-allocate data cache between the pipeline's D-cache port and the slow data memory. It serves word loads and stores from the MEM stage. On a miss it holds `proc_stall` high, writes back a dirty victim if there is one, and refills a 4-word block. The pipeline freezes on `proc_stall`, so the request stays stable until the cache releases it.

---
 rtl/dcache_pkg.sv | 28 ++
 rtl/dcache_line_store.sv | 65 ++++++
 rtl/dcache_wb_dm.sv | 125 ++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared types, widths and helpers for the direct-mapped write-back data cache.
package dcache_pkg;

    localparam int unsigned WORD_W          = 32;
    localparam int unsigned WORDS_PER_BLOCK = 4;
    localparam int unsigned BLOCK_W         = WORD_W * WORDS_PER_BLOCK;
    localparam int unsigned ADDR_W          = 30;
    localparam int unsigned OFF_W           = 2;
    localparam int unsigned BLK_ADDR_W      = ADDR_W - OFF_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WB    = 2'd1,
        S_ALLOC = 2'd2
    } state_e;

    // Word 0 occupies the least significant 32 bits of the block.
    typedef logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0] block_t;

    function automatic int unsigned idx_w(input int unsigned num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int unsigned tag_w(input int unsigned num_sets);
        return BLK_ADDR_W - $clog2(num_sets);
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Valid/dirty/tag/data arrays: one combinational read port, one word-write port, one block-fill port.
module dcache_line_store
    import dcache_pkg::*;
#(
    parameter  int unsigned NUM_SETS = 8,
    localparam int unsigned IDX_W    = idx_w(NUM_SETS),
    localparam int unsigned TAG_W    = tag_w(NUM_SETS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  idx,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output block_t            rd_data,
    input  logic              wr_en,
    input  logic [OFF_W-1:0]  wr_off,
    input  logic [WORD_W-1:0] wr_word,
    input  logic              fill_en,
    input  logic [TAG_W-1:0]  fill_tag,
    input  block_t            fill_data
);

    logic [NUM_SETS-1:0]             valid_q, valid_d;
    logic [NUM_SETS-1:0]             dirty_q, dirty_d;
    logic [NUM_SETS-1:0][TAG_W-1:0]  tag_q,   tag_d;
    block_t [NUM_SETS-1:0]           data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        // A fill always leaves the line clean; a store on the following hit marks it dirty.
        if (fill_en) begin
            valid_d[idx] = 1'b1;
            dirty_d[idx] = 1'b0;
            tag_d[idx]   = fill_tag;
            data_d[idx]  = fill_data;
        end else if (wr_en) begin
            dirty_d[idx]         = 1'b1;
            data_d[idx][wr_off]  = wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_data  = data_q[idx];

endmodule

// File: rtl/dcache_wb_dm.sv
// Direct-mapped write-back write-allocate D-cache: hit/miss detection and the IDLE/WB/ALLOC miss FSM.
module dcache_wb_dm
    import dcache_pkg::*;
#(
    parameter int unsigned NUM_SETS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  proc_read,
    input  logic                  proc_write,
    input  logic [ADDR_W-1:0]     proc_addr,
    input  logic [WORD_W-1:0]     proc_wdata,
    output logic                  proc_stall,
    output logic [WORD_W-1:0]     proc_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [BLK_ADDR_W-1:0] mem_addr,
    output logic [BLOCK_W-1:0]    mem_wdata,
    input  logic [BLOCK_W-1:0]    mem_rdata,
    input  logic                  mem_ready
);

    localparam int unsigned IDX_W = idx_w(NUM_SETS);
    localparam int unsigned TAG_W = tag_w(NUM_SETS);

    state_e            state_q, state_d;
    logic [OFF_W-1:0]  req_off;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              req;
    logic              hit;
    logic              line_valid;
    logic              line_dirty;
    logic [TAG_W-1:0]  line_tag;
    block_t            line_data;
    logic              wr_en;
    logic              fill_en;

    assign req_off = proc_addr[OFF_W-1:0];
    assign req_idx = proc_addr[IDX_W+OFF_W-1:OFF_W];
    assign req_tag = proc_addr[ADDR_W-1:IDX_W+OFF_W];
    assign req     = proc_read | proc_write;
    assign hit     = line_valid && (line_tag == req_tag);

    dcache_line_store #(
        .NUM_SETS (NUM_SETS)
    ) u_store (
        .clk       (clk),
        .rst_n     (rst_n),
        .idx       (req_idx),
        .rd_valid  (line_valid),
        .rd_dirty  (line_dirty),
        .rd_tag    (line_tag),
        .rd_data   (line_data),
        .wr_en     (wr_en),
        .wr_off    (req_off),
        .wr_word   (proc_wdata),
        .fill_en   (fill_en),
        .fill_tag  (req_tag),
        .fill_data (block_t'(mem_rdata))
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus stall/array strobes; a store wins when both requests are high.
    always_comb begin
        state_d    = state_q;
        proc_stall = 1'b0;
        wr_en      = 1'b0;
        fill_en    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (hit) begin
                        wr_en = proc_write;
                    end else begin
                        proc_stall = 1'b1;
                        state_d    = (line_valid && line_dirty) ? S_WB : S_ALLOC;
                    end
                end
            end
            S_WB: begin
                proc_stall = 1'b1;
                if (mem_ready) begin
                    state_d = S_ALLOC;
                end
            end
            S_ALLOC: begin
                proc_stall = 1'b1;
                if (mem_ready) begin
                    fill_en = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Memory-side strobes come straight from the state register.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == S_WB) begin
            mem_write = 1'b1;
            mem_addr  = {line_tag, req_idx};
            mem_wdata = BLOCK_W'(line_data);
        end else if (state_q == S_ALLOC) begin
            mem_read  = 1'b1;
            mem_addr  = {req_tag, req_idx};
        end
    end

    assign proc_rdata = line_data[req_off];

endmodule
